// File: rtl/icache_mshr_ctrl_if.sv
// rtl/icache_mshr_ctrl_if.sv - fetch, cache-array and memory-bus signal bundle for icache_mshr_ctrl
//
// slave  : the MSHR controller (consumes fetch/cache/memory inputs, drives bus and fill outputs)
// master : the surrounding fetch stage, cache array and memory model
interface icache_mshr_ctrl_if #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 24
);
  logic                  proc2Icache_req;
  logic [31:0]           proc2Icache_addr;
  logic                  cachemem_hit;
  logic [63:0]           cachemem_data;
  logic                  cachemem_next_hit;
  logic [3:0]            Imem2proc_response;
  logic [3:0]            Imem2proc_tag;
  logic [63:0]           Imem2proc_data;
  logic [1:0]            proc2Imem_command;
  logic [31:0]           proc2Imem_addr;
  logic                  cachemem_wr_en;
  logic [INDEX_BITS-1:0] cachemem_wr_index;
  logic [TAG_BITS-1:0]   cachemem_wr_tag;
  logic [63:0]           cachemem_wr_data;
  logic [63:0]           Icache_data_out;
  logic                  Icache_valid_out;
  logic                  mshr_full;

  modport slave (
    input  proc2Icache_req, proc2Icache_addr, cachemem_hit, cachemem_data, cachemem_next_hit,
    input  Imem2proc_response, Imem2proc_tag, Imem2proc_data,
    output proc2Imem_command, proc2Imem_addr,
    output cachemem_wr_en, cachemem_wr_index, cachemem_wr_tag, cachemem_wr_data,
    output Icache_data_out, Icache_valid_out, mshr_full
  );

  modport master (
    output proc2Icache_req, proc2Icache_addr, cachemem_hit, cachemem_data, cachemem_next_hit,
    output Imem2proc_response, Imem2proc_tag, Imem2proc_data,
    input  proc2Imem_command, proc2Imem_addr,
    input  cachemem_wr_en, cachemem_wr_index, cachemem_wr_tag, cachemem_wr_data,
    input  Icache_data_out, Icache_valid_out, mshr_full
  );
endinterface

// File: rtl/icache_mshr_ctrl.sv
// rtl/icache_mshr_ctrl.sv - instruction-cache miss status holding register controller
//
// Tracks up to NUM_MSHR outstanding line misses. Each entry is FREE, ISSUE (waiting for the
// memory to accept the load) or WAIT (accepted, waiting for the fill carrying its mem tag).
// Optional next-line prefetch is compiled in with `define ICACHE_PREFETCH_EN.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-low reset
//   clear  - synchronous flush of ISSUE entries (WAIT entries survive)
//   bus    - icache_mshr_ctrl_if.slave:
//            fetch request/address, cache-array hit/data/next_hit, memory response/fill tag/data in;
//            memory command/address, cache-array write port, fetch data/valid, mshr_full out
module icache_mshr_ctrl #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 24,
  parameter int NUM_MSHR   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  icache_mshr_ctrl_if.slave  bus
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int         IW       = $clog2(NUM_MSHR);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } mshr_state_e;

  mshr_state_e state_q [NUM_MSHR];
  logic [28:0] line_q  [NUM_MSHR];
  logic [3:0]  mtag_q  [NUM_MSHR];

  logic [28:0]   fetch_line;
  logic [28:0]   next_line;
  logic          issue_found;
  logic [IW-1:0] issue_idx;
  logic          fill_found;
  logic [IW-1:0] fill_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [3:0]    free_cnt;
  logic          demand_match;
  logic          next_match;
  logic          cmd_load;
  logic          accept;
  logic          bypass;
  logic          demand_alloc;
  logic          prefetch_alloc;
  logic          alloc;
  logic [28:0]   alloc_line;
  logic [2:0]    unused_addr_lo;

  assign fetch_line     = bus.proc2Icache_addr[31:3];
  assign next_line      = fetch_line + 29'd1;  // wraps 0x1FFFFFFF -> 0 by width
  assign unused_addr_lo = bus.proc2Icache_addr[2:0];

  // Scan from the top down so the lowest-index match is the one that sticks.
  always_comb begin
    issue_found  = 1'b0;
    issue_idx    = '0;
    fill_found   = 1'b0;
    fill_idx     = '0;
    free_found   = 1'b0;
    free_idx     = '0;
    free_cnt     = 4'd0;
    demand_match = 1'b0;
    next_match   = 1'b0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (state_q[i] == ISSUE) begin
        issue_found = 1'b1;
        issue_idx   = IW'(i);
      end
      // Only entries already in WAIT can match; a tag accepted this cycle is not yet visible.
      if (state_q[i] == WAIT && bus.Imem2proc_tag != 4'd0 && mtag_q[i] == bus.Imem2proc_tag) begin
        fill_found = 1'b1;
        fill_idx   = IW'(i);
      end
      if (state_q[i] == FREE) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
        free_cnt   = free_cnt + 4'd1;
      end
      if (state_q[i] != FREE && line_q[i] == fetch_line) demand_match = 1'b1;
      if (state_q[i] != FREE && line_q[i] == next_line)  next_match   = 1'b1;
    end
  end

  // Fullness comes from registered state only, so a fill freeing an entry helps next cycle.
  assign bus.mshr_full = ~free_found;

  assign cmd_load              = issue_found && !clear;
  assign accept                = cmd_load && (bus.Imem2proc_response != 4'd0);
  assign bus.proc2Imem_command = cmd_load ? BUS_LOAD : BUS_NONE;
  assign bus.proc2Imem_addr    = cmd_load ? {line_q[issue_idx], 3'b000} : 32'd0;

  assign bus.cachemem_wr_en    = fill_found;
  assign bus.cachemem_wr_index = line_q[fill_idx][INDEX_BITS-1:0];
  assign bus.cachemem_wr_tag   = line_q[fill_idx][INDEX_BITS +: TAG_BITS];
  assign bus.cachemem_wr_data  = bus.Imem2proc_data;

  // A fill for the line being fetched right now is forwarded straight to the fetch stage.
  assign bypass               = fill_found && (line_q[fill_idx] == fetch_line);
  assign bus.Icache_valid_out = reset && (bypass || bus.cachemem_hit);
  assign bus.Icache_data_out  = bypass ? bus.Imem2proc_data : bus.cachemem_data;

  assign demand_alloc = bus.proc2Icache_req && !bus.cachemem_hit && !demand_match &&
                        !bus.mshr_full && !clear;

`ifdef ICACHE_PREFETCH_EN
  // Keep one entry in reserve so a prefetch never starves the next demand miss.
  assign prefetch_alloc = !demand_alloc && bus.proc2Icache_req && !bus.cachemem_next_hit &&
                          !next_match && (free_cnt >= 4'd2) && !clear;
`else
  logic unused_prefetch;
  assign prefetch_alloc  = 1'b0;
  assign unused_prefetch = ^{bus.cachemem_next_hit, next_match, free_cnt};
`endif

  assign alloc      = demand_alloc || prefetch_alloc;
  assign alloc_line = demand_alloc ? fetch_line : next_line;

  // The four transitions touch entries in distinct states, so at most one applies per entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        state_q[i] <= FREE;
        line_q[i]  <= '0;
        mtag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) begin
        if (clear && state_q[i] == ISSUE) begin
          state_q[i] <= FREE;
        end else if (accept && issue_idx == IW'(i)) begin
          state_q[i] <= WAIT;
          mtag_q[i]  <= bus.Imem2proc_response;
        end else if (fill_found && fill_idx == IW'(i)) begin
          state_q[i] <= FREE;
        end else if (alloc && free_idx == IW'(i)) begin
          state_q[i] <= ISSUE;
          line_q[i]  <= alloc_line;
        end
      end
    end
  end
endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// tb/tb_icache_mshr_ctrl.sv - directed and randomized self-checking bench for icache_mshr_ctrl
module tb_icache_mshr_ctrl;
  localparam int IB = 5;
  localparam int TB = 24;
  localparam int NM = 4;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  icache_mshr_ctrl_if #(.INDEX_BITS(IB), .TAG_BITS(TB)) bus ();

  icache_mshr_ctrl #(.INDEX_BITS(IB), .TAG_BITS(TB), .NUM_MSHR(NM)) dut (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a table of outstanding misses; "accepted" means memory took the load.
  typedef struct packed {
    bit          busy;
    bit          accepted;
    logic [28:0] line;
    logic [3:0]  mtag;
  } slot_t;

  slot_t slots   [NM];
  slot_t n_slots [NM];

  logic [1:0]    e_cmd;
  logic [31:0]   e_addr;
  logic          e_wr;
  logic [IB-1:0] e_idx;
  logic [TB-1:0] e_tag;
  logic          e_valid;
  logic [63:0]   e_dout;
  logic          e_full;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit req, input logic [31:0] addr, input bit hit, input bit nhit,
                        input logic [3:0] resp, input logic [3:0] ftag);
    bus.proc2Icache_req    = req;
    bus.proc2Icache_addr   = addr;
    bus.cachemem_hit       = hit;
    bus.cachemem_next_hit  = nhit;
    bus.cachemem_data      = {$urandom, $urandom};
    bus.Imem2proc_response = resp;
    bus.Imem2proc_tag      = ftag;
    bus.Imem2proc_data     = {$urandom, $urandom};
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NM; i++) slots[i] = '0;
  endtask

  // Expected outputs for the current inputs, plus the table after the coming edge.
  task automatic model_cycle();
    int li, fi, fr, nfree;
    bit dup, ndup, dem;
    logic [28:0] fl, nl;
    fl = bus.proc2Icache_addr[31:3];
    nl = fl + 29'd1;
    li = -1; fi = -1; fr = -1; nfree = 0; dup = 0; ndup = 0;
    for (int i = 0; i < NM; i++) begin
      if (slots[i].busy && !slots[i].accepted && li < 0) li = i;
      if (slots[i].busy && slots[i].accepted && bus.Imem2proc_tag != 0 &&
          slots[i].mtag == bus.Imem2proc_tag && fi < 0) fi = i;
      if (!slots[i].busy) begin
        nfree++;
        if (fr < 0) fr = i;
      end
      if (slots[i].busy && slots[i].line == fl) dup = 1;
      if (slots[i].busy && slots[i].line == nl) ndup = 1;
    end
    e_full = (nfree == 0);
    e_cmd  = BUS_NONE;
    e_addr = 32'd0;
    if (li >= 0 && !clear) begin
      e_cmd  = BUS_LOAD;
      e_addr = {slots[li].line, 3'b000};
    end
    e_wr = (fi >= 0);
    e_idx = '0;
    e_tag = '0;
    e_valid = bus.cachemem_hit;
    e_dout  = bus.cachemem_data;
    if (fi >= 0) begin
      e_idx = slots[fi].line % (1 << IB);
      e_tag = TB'(slots[fi].line / (1 << IB));
      if (slots[fi].line == fl) begin
        e_valid = 1'b1;
        e_dout  = bus.Imem2proc_data;
      end
    end
    n_slots = slots;
    if (e_cmd == BUS_LOAD && bus.Imem2proc_response != 0) begin
      n_slots[li].accepted = 1;
      n_slots[li].mtag     = bus.Imem2proc_response;
    end
    if (fi >= 0) n_slots[fi] = '0;
    if (clear)
      for (int i = 0; i < NM; i++)
        if (slots[i].busy && !slots[i].accepted) n_slots[i] = '0;
    dem = bus.proc2Icache_req && !bus.cachemem_hit && !dup && !e_full && !clear;
    if (dem) begin
      n_slots[fr].busy = 1; n_slots[fr].accepted = 0; n_slots[fr].line = fl;
    end
`ifdef ICACHE_PREFETCH_EN
    else if (bus.proc2Icache_req && !bus.cachemem_next_hit && !ndup && nfree >= 2 && !clear) begin
      n_slots[fr].busy = 1; n_slots[fr].accepted = 0; n_slots[fr].line = nl;
    end
`endif
  endtask

  task automatic tick();
    model_cycle();
    chk("cmd", 64'(bus.proc2Imem_command), 64'(e_cmd));
    if (e_cmd == BUS_LOAD) chk("mem_addr", 64'(bus.proc2Imem_addr), 64'(e_addr));
    chk("wr_en", 64'(bus.cachemem_wr_en), 64'(e_wr));
    if (e_wr) begin
      chk("wr_index", 64'(bus.cachemem_wr_index), 64'(e_idx));
      chk("wr_tag", 64'(bus.cachemem_wr_tag), 64'(e_tag));
      chk("wr_data", bus.cachemem_wr_data, bus.Imem2proc_data);
    end
    chk("valid_out", 64'(bus.Icache_valid_out), 64'(e_valid));
    if (e_valid) chk("data_out", bus.Icache_data_out, e_dout);
    chk("mshr_full", 64'(bus.mshr_full), 64'(e_full));
    @(posedge clock);
    slots = n_slots;
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear = 1'b0;
    set_in(0, 32'd0, 0, 1, 4'd0, 4'd0);
    model_clear();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int acc;
    logic [28:0] pool [6];
    pool[0] = 29'h200; pool[1] = 29'h201; pool[2] = 29'h202;
    pool[3] = 29'h1FFFFFFF; pool[4] = 29'h0; pool[5] = 29'h340;

    // Reset values are held while reset is low, even with hit and a fill tag present.
    set_in(1, 32'h1000, 1, 0, 4'd3, 4'd7);
    chk("rst_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    chk("rst_wr_en", 64'(bus.cachemem_wr_en), 64'd0);
    chk("rst_valid", 64'(bus.Icache_valid_out), 64'd0);
    chk("rst_full", 64'(bus.mshr_full), 64'd0);

    // Single miss: load at N+1, fill with tag 3 at N+5, bypassed to the fetch stage.
    do_reset();
    set_in(1, 32'h1000, 0, 1, 4'd0, 4'd0);
    chk("r025_cmd_n", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    tick();
    set_in(1, 32'h1000, 0, 1, 4'd3, 4'd0);
    chk("r025_cmd_n1", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
    chk("r025_addr_n1", 64'(bus.proc2Imem_addr), 64'h1000);
    tick();
    for (int k = 0; k < 3; k++) begin
      set_in(1, 32'h1000, 0, 1, 4'd0, 4'd0);
      tick();
    end
    set_in(1, 32'h1000, 0, 1, 4'd0, 4'd3);
    chk("r025_wr_en", 64'(bus.cachemem_wr_en), 64'd1);
    chk("r025_wr_index", 64'(bus.cachemem_wr_index), 64'h00);
    chk("r025_wr_tag", 64'(bus.cachemem_wr_tag), 64'h000010);
    chk("r025_valid", 64'(bus.Icache_valid_out), 64'd1);
    chk("r025_bypass", bus.Icache_data_out, bus.Imem2proc_data);
    tick();
    set_in(0, 32'h1000, 0, 1, 4'd0, 4'd0);
    tick();

    // Rejected three times, then accepted with tag 5.
    do_reset();
    set_in(1, 32'h4000, 0, 1, 4'd0, 4'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      set_in(1, 32'h4000, 0, 1, (k == 3) ? 4'd5 : 4'd0, 4'd0);
      chk("r026_cmd", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
      chk("r026_addr", 64'(bus.proc2Imem_addr), 64'h4000);
      tick();
    end
    set_in(0, 32'h0, 0, 1, 4'd0, 4'd0);
    chk("r026_idle", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    tick();
    set_in(0, 32'h0, 0, 1, 4'd0, 4'd5);
    chk("r026_fill", 64'(bus.cachemem_wr_en), 64'd1);
    chk("r026_tag", 64'(bus.cachemem_wr_tag), 64'h000040);
    tick();

    // Fill all four entries, block a fifth miss, free one, fifth allocated a cycle later.
    do_reset();
    set_in(1, 32'h5000, 0, 1, 4'd0, 4'd0); tick();
    set_in(1, 32'h6000, 0, 1, 4'd1, 4'd0); tick();
    set_in(1, 32'h7000, 0, 1, 4'd2, 4'd0); tick();
    set_in(1, 32'h8000, 0, 1, 4'd3, 4'd0); tick();
    set_in(1, 32'h9000, 0, 1, 4'd4, 4'd0);
    chk("r027_full", 64'(bus.mshr_full), 64'd1);
    tick();
    set_in(1, 32'h9000, 0, 1, 4'd0, 4'd0);
    chk("r027_blocked", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    tick();
    set_in(1, 32'h9000, 0, 1, 4'd0, 4'd2);
    chk("r027_fill", 64'(bus.cachemem_wr_en), 64'd1);
    chk("r027_full_fill", 64'(bus.mshr_full), 64'd1);
    tick();
    set_in(1, 32'h9000, 0, 1, 4'd0, 4'd0);
    chk("r027_freed", 64'(bus.mshr_full), 64'd0);
    tick();
    set_in(1, 32'h9000, 0, 1, 4'd0, 4'd0);
    chk("r027_fifth_cmd", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
    chk("r027_fifth_addr", 64'(bus.proc2Imem_addr), 64'h9000);
    tick();

    // Same line held for 10 cycles is requested once; a stray fill tag writes nothing.
    do_reset();
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      set_in(1, 32'hA000, 0, 1, 4'd6, 4'd0);
      if (bus.proc2Imem_command == BUS_LOAD) acc++;
      tick();
    end
    chk("r028_accepts", 64'(acc), 64'd1);
    set_in(0, 32'h0, 0, 1, 4'd0, 4'd9);
    chk("r028_stray", 64'(bus.cachemem_wr_en), 64'd0);
    tick();
    set_in(0, 32'h0, 0, 1, 4'd0, 4'd6); tick();

    // Next-line prefetch, including wrap at the top of the address space.
    do_reset();
    set_in(1, 32'h2000, 1, 0, 4'd0, 4'd0); tick();
    set_in(1, 32'h2000, 1, 1, 4'd0, 4'd0);
`ifdef ICACHE_PREFETCH_EN
    chk("r029_cmd", 64'(bus.proc2Imem_command), 64'(BUS_LOAD));
    chk("r029_addr", 64'(bus.proc2Imem_addr), 64'h2008);
`else
    chk("r029_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
`endif
    tick();
    do_reset();
    set_in(1, 32'hFFFF_FFF8, 1, 0, 4'd0, 4'd0); tick();
    set_in(1, 32'hFFFF_FFF8, 1, 1, 4'd0, 4'd0);
`ifdef ICACHE_PREFETCH_EN
    chk("wrap_addr", 64'(bus.proc2Imem_addr), 64'h0);
`else
    chk("wrap_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
`endif
    tick();

    // Clear drops an unissued miss and silences the bus that cycle.
    do_reset();
    set_in(1, 32'hB000, 0, 1, 4'd0, 4'd0); tick();
    set_in(1, 32'hB000, 0, 1, 4'd4, 4'd0);
    clear = 1'b1;
    #1;
    chk("clr_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    tick();
    clear = 1'b0;
    set_in(0, 32'h0, 0, 1, 4'd4, 4'd0);
    chk("clr_freed", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    tick();

    // Reset while waiting on tag 7; the later tag-7 fill is stale.
    do_reset();
    set_in(1, 32'h3000, 0, 1, 4'd0, 4'd0); tick();
    set_in(1, 32'h3000, 0, 1, 4'd7, 4'd0); tick();
    set_in(1, 32'h3000, 1, 1, 4'd0, 4'd7);
    reset = 1'b0;
    #1;
    model_clear();
    chk("r030_cmd", 64'(bus.proc2Imem_command), 64'(BUS_NONE));
    chk("r030_wr_en", 64'(bus.cachemem_wr_en), 64'd0);
    chk("r030_valid", 64'(bus.Icache_valid_out), 64'd0);
    chk("r030_full", 64'(bus.mshr_full), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    set_in(0, 32'h3000, 0, 1, 4'd0, 4'd7);
    chk("r030_stale", 64'(bus.cachemem_wr_en), 64'd0);
    tick();

    // Randomized traffic over a small line pool so duplicates, fullness and wrap occur.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      logic [28:0] ln;
      logic [3:0]  resp, ftag;
      bit used;
      int pick;
      ln   = pool[$urandom_range(0, 5)];
      resp = 4'd0;
      if ($urandom_range(0, 2) != 0) begin
        for (int t = 0; t < 32 && resp == 0; t++) begin
          resp = 4'($urandom_range(1, 15));
          used = 0;
          for (int i = 0; i < NM; i++)
            if (slots[i].busy && slots[i].accepted && slots[i].mtag == resp) used = 1;
          if (used) resp = 4'd0;
        end
      end
      ftag = 4'd0;
      pick = $urandom_range(0, 3);
      if (pick == 1) ftag = 4'($urandom_range(1, 15));
      else if (pick >= 2) begin
        int s;
        s = $urandom_range(0, NM - 1);
        if (slots[s].busy && slots[s].accepted) ftag = slots[s].mtag;
      end
      clear = ($urandom_range(0, 19) == 0);
      set_in($urandom_range(0, 9) != 0, {ln, 3'($urandom_range(0, 7))},
             $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, resp, ftag);
      tick();
    end
    clear = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
